// File: rtl/tage_update_queue.sv
// In-order tracking queue of in-flight predicted branches feeding the TAGE T0 update port.
// Entries are resolved out of order, retire in allocation order, and can be squashed by a mispredict flush.
module tage_update_queue #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  // Alloc handshake: an entry is written on a rising edge where i_alloc_valid && o_alloc_ready.
  // o_alloc_ready never waits on i_alloc_valid; valid without ready is dropped, not held.
  input  logic             i_alloc_valid,
  input  logic [31:0]      i_alloc_pc,
  input  logic [1:0]       i_alloc_pred,
  output logic             o_alloc_ready,
  output logic [TAG_W-1:0] o_alloc_tag,
  input  logic             i_resolve_valid,
  input  logic [TAG_W-1:0] i_resolve_tag,
  input  logic             i_resolve_taken,
  input  logic             i_flush_valid,
  input  logic [TAG_W-1:0] i_flush_tag,
  output logic             o_update_valid,
  output logic [31:0]      o_update_pc,
  output logic             o_update_taken,
  output logic [1:0]       o_update_pred,
  output logic [TAG_W:0]   o_count
);

  logic [TAG_W:0]   r_head;
  logic [TAG_W:0]   r_tail;
  logic [31:0]      r_pc [DEPTH];
  logic [1:0]       r_pred [DEPTH];
  logic [DEPTH-1:0] r_taken;
  logic [DEPTH-1:0] r_resolved;

  logic             r_update_valid;
  logic [31:0]      r_update_pc;
  logic             r_update_taken;
  logic [1:0]       r_update_pred;

  logic [TAG_W:0]   w_count;
  logic [TAG_W-1:0] w_head_idx;
  logic [TAG_W-1:0] w_tail_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_alloc_fire;
  logic [TAG_W-1:0] w_flush_off;
  logic             w_flush_live;
  logic [TAG_W-1:0] w_res_off;
  logic             w_res_live;
  logic             w_res_survives;
  logic             w_res_apply;
  logic             w_retire;
  logic [TAG_W-1:0] w_slot_off [DEPTH];
  logic [DEPTH-1:0] w_squash;
  logic [DEPTH-1:0] w_resolved_nxt;
  logic [TAG_W:0]   w_head_nxt;
  logic [TAG_W:0]   w_tail_nxt;

  assign w_count    = r_tail - r_head;
  assign w_head_idx = r_head[TAG_W-1:0];
  assign w_tail_idx = r_tail[TAG_W-1:0];
  assign w_full     = (w_count == (TAG_W+1)'(DEPTH));
  assign w_empty    = (w_count == '0);

  assign o_alloc_ready = !w_full && !i_flush_valid;
  assign o_alloc_tag   = w_tail_idx;
  assign o_count       = w_count;
  assign w_alloc_fire  = i_alloc_valid && o_alloc_ready;

  // Offsets are distances from head modulo DEPTH; a slot is live when its offset is below count.
  assign w_flush_off  = i_flush_tag - w_head_idx;
  assign w_flush_live = i_flush_valid && ({1'b0, w_flush_off} < w_count);

  assign w_res_off      = i_resolve_tag - w_head_idx;
  assign w_res_live     = ({1'b0, w_res_off} < w_count);
  assign w_res_survives = !w_flush_live || (w_res_off <= w_flush_off);
  assign w_res_apply    = i_resolve_valid && w_res_live && w_res_survives &&
                          !r_resolved[i_resolve_tag];

  // Resolved is only set on a live entry, so a resolved head implies a retire-ready entry.
  assign w_retire = !w_empty && r_resolved[w_head_idx];

  always_comb begin
    w_squash = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_slot_off[i] = TAG_W'(i) - w_head_idx;
      w_squash[i]   = w_flush_live && (w_slot_off[i] > w_flush_off) &&
                      ({1'b0, w_slot_off[i]} < w_count);
    end
  end

  always_comb begin
    w_resolved_nxt = r_resolved;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_squash[i]) begin
        w_resolved_nxt[i] = 1'b0;
      end
      if (w_retire && (w_head_idx == TAG_W'(i))) begin
        w_resolved_nxt[i] = 1'b0;
      end
      if (w_alloc_fire && (w_tail_idx == TAG_W'(i))) begin
        w_resolved_nxt[i] = 1'b0;
      end
      if (w_res_apply && (i_resolve_tag == TAG_W'(i))) begin
        w_resolved_nxt[i] = 1'b1;
      end
    end
  end

  // Flush rebuilds tail from the pre-retire head so the flushing entry itself is always kept.
  always_comb begin
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    if (w_retire) begin
      w_head_nxt = r_head + (TAG_W+1)'(1);
    end
    if (w_flush_live) begin
      w_tail_nxt = r_head + {1'b0, w_flush_off} + (TAG_W+1)'(1);
    end else if (w_alloc_fire) begin
      w_tail_nxt = r_tail + (TAG_W+1)'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_resolved <= '0;
    end else begin
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_resolved <= w_resolved_nxt;
    end
  end

  // Payload storage carries no reset: it is only read behind a set resolved bit.
  always_ff @(posedge i_clk) begin
    if (w_alloc_fire) begin
      r_pc[w_tail_idx]   <= i_alloc_pc;
      r_pred[w_tail_idx] <= i_alloc_pred;
    end
    if (w_res_apply) begin
      r_taken[i_resolve_tag] <= i_resolve_taken;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_update_valid <= 1'b0;
      r_update_pc    <= '0;
      r_update_taken <= 1'b0;
      r_update_pred  <= '0;
    end else begin
      r_update_valid <= w_retire;
      if (w_retire) begin
        r_update_pc    <= r_pc[w_head_idx];
        r_update_taken <= r_taken[w_head_idx];
        r_update_pred  <= r_pred[w_head_idx];
      end
    end
  end

  assign o_update_valid = r_update_valid;
  assign o_update_pc    = r_update_pc;
  assign o_update_taken = r_update_taken;
  assign o_update_pred  = r_update_pred;

endmodule

// File: tb/tb_tage_update_queue.sv
// Directed bench for tage_update_queue: alloc/resolve/retire ordering, full/wrap, flush squash and async reset.
module tb_tage_update_queue;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  logic             clk;
  logic             rst;
  logic             alloc_valid;
  logic [31:0]      alloc_pc;
  logic [1:0]       alloc_pred;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic             resolve_taken;
  logic             flush_valid;
  logic [TAG_W-1:0] flush_tag;
  logic             update_valid;
  logic [31:0]      update_pc;
  logic             update_taken;
  logic [1:0]       update_pred;
  logic [TAG_W:0]   count;

  int tests_run = 0;
  int tests_failed = 0;

  tage_update_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alloc_valid(alloc_valid), .i_alloc_pc(alloc_pc), .i_alloc_pred(alloc_pred),
    .o_alloc_ready(alloc_ready), .o_alloc_tag(alloc_tag),
    .i_resolve_valid(resolve_valid), .i_resolve_tag(resolve_tag), .i_resolve_taken(resolve_taken),
    .i_flush_valid(flush_valid), .i_flush_tag(flush_tag),
    .o_update_valid(update_valid), .o_update_pc(update_pc),
    .o_update_taken(update_taken), .o_update_pred(update_pred),
    .o_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic [1:0] pred);
    alloc_valid = 1'b1;
    alloc_pc    = pc;
    alloc_pred  = pred;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_resolve(input logic [TAG_W-1:0] tag, input logic taken);
    resolve_valid = 1'b1;
    resolve_tag   = tag;
    resolve_taken = taken;
    tick();
    resolve_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_update(input string tag, input logic [31:0] pc, input logic taken,
                            input logic [1:0] pred);
    chk({tag, "_valid"}, 40'(update_valid), 40'(1));
    chk({tag, "_pc"},    40'(update_pc),    40'(pc));
    chk({tag, "_taken"}, 40'(update_taken), 40'(taken));
    chk({tag, "_pred"},  40'(update_pred),  40'(pred));
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_pc = '0; alloc_pred = '0;
    resolve_valid = 1'b0; resolve_tag = '0; resolve_taken = 1'b0;
    flush_valid = 1'b0; flush_tag = '0;
    tick();
    tick();
    chk("rst_count", 40'(count), 40'(0));
    chk("rst_ready", 40'(alloc_ready), 40'(1));
    chk("rst_tag", 40'(alloc_tag), 40'(0));
    chk("rst_uvalid", 40'(update_valid), 40'(0));
    chk("rst_upc", 40'(update_pc), 40'(0));
    rst = 1'b0;

    // Three allocations in slots 0..2
    for (int i = 0; i < 3; i++) begin
      chk("t1_alloc_tag", 40'(alloc_tag), 40'(i));
      do_alloc(32'h100 + 32'(4 * i), 2'(i + 1));
    end
    chk("t1_count", 40'(count), 40'(3));
    chk("t1_uvalid", 40'(update_valid), 40'(0));

    // Out-of-order resolve, in-order retire
    do_resolve(4'd2, 1'b1);
    chk("t2_no_upd_a", 40'(update_valid), 40'(0));
    do_resolve(4'd0, 1'b0);
    chk("t2_no_upd_b", 40'(update_valid), 40'(0));
    do_resolve(4'd1, 1'b1);
    chk_update("t2_upd0", 32'h100, 1'b0, 2'b01);
    tick();
    chk_update("t2_upd1", 32'h104, 1'b1, 2'b10);
    tick();
    chk_update("t2_upd2", 32'h108, 1'b1, 2'b11);
    chk("t2_count", 40'(count), 40'(0));
    tick();
    chk("t2_idle", 40'(update_valid), 40'(0));

    // Fill to DEPTH, refuse 17th, retire head, wrapped alloc lands in slot 0
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      do_alloc(32'h200 + 32'(4 * i), 2'(i % 4));
    end
    chk("t3_full_count", 40'(count), 40'(16));
    chk("t3_full_ready", 40'(alloc_ready), 40'(0));
    chk("t3_full_tag", 40'(alloc_tag), 40'(0));
    do_alloc(32'hdead, 2'b11);
    chk("t3_drop_count", 40'(count), 40'(16));
    do_resolve(4'd0, 1'b1);
    chk("t3_res_count", 40'(count), 40'(16));
    tick();
    chk_update("t3_ret0", 32'h200, 1'b1, 2'b00);
    chk("t3_ret_count", 40'(count), 40'(15));
    chk("t3_ret_ready", 40'(alloc_ready), 40'(1));
    chk("t3_ret_tag", 40'(alloc_tag), 40'(0));
    do_alloc(32'h300, 2'b10);
    chk("t3_refill_count", 40'(count), 40'(16));
    for (int i = 0; i < DEPTH; i++) begin
      resolve_valid = 1'b1;
      resolve_tag   = 4'((i + 1) % DEPTH);
      resolve_taken = 1'b1;
      tick();
      if (i > 0) begin
        chk("t3_drain_valid", 40'(update_valid), 40'(1));
        chk("t3_drain_pc", 40'(update_pc), 40'(32'h200 + 32'(4 * i)));
      end
    end
    resolve_valid = 1'b0;
    tick();
    chk_update("t3_wrapped", 32'h300, 1'b1, 2'b10);
    chk("t3_empty", 40'(count), 40'(0));

    // Flush tag1 keeps 0..1, a squashed resolve has no effect
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_alloc(32'h400 + 32'(4 * i), 2'b00);
    end
    chk("t4_count5", 40'(count), 40'(5));
    flush_valid = 1'b1;
    flush_tag   = 4'd1;
    #1;
    chk("t4_flush_ready", 40'(alloc_ready), 40'(0));
    tick();
    flush_valid = 1'b0;
    chk("t4_count", 40'(count), 40'(2));
    chk("t4_tag", 40'(alloc_tag), 40'(2));
    do_resolve(4'd3, 1'b1);
    chk("t4_dead_res_cnt", 40'(count), 40'(2));
    chk("t4_dead_res_upd", 40'(update_valid), 40'(0));
    do_resolve(4'd0, 1'b0);
    do_resolve(4'd1, 1'b1);
    chk_update("t4_upd0", 32'h400, 1'b0, 2'b00);
    tick();
    chk_update("t4_upd1", 32'h404, 1'b1, 2'b00);
    chk("t4_empty", 40'(count), 40'(0));
    tick();
    chk("t4_no_upd3", 40'(update_valid), 40'(0));

    // Flush with simultaneous alloc and resolve of a squashed tag (slots 2..5 live)
    for (int i = 0; i < 4; i++) begin
      do_alloc(32'h500 + 32'(4 * i), 2'b01);
    end
    chk("t5_count4", 40'(count), 40'(4));
    flush_valid   = 1'b1;
    flush_tag     = 4'd3;
    alloc_valid   = 1'b1;
    alloc_pc      = 32'hbad0;
    alloc_pred    = 2'b11;
    resolve_valid = 1'b1;
    resolve_tag   = 4'd4;
    resolve_taken = 1'b1;
    #1;
    chk("t5_ready", 40'(alloc_ready), 40'(0));
    tick();
    flush_valid = 1'b0; alloc_valid = 1'b0; resolve_valid = 1'b0;
    chk("t5_count", 40'(count), 40'(2));
    chk("t5_tag", 40'(alloc_tag), 40'(4));
    do_resolve(4'd2, 1'b0);
    do_resolve(4'd3, 1'b0);
    chk_update("t5_upd2", 32'h500, 1'b0, 2'b01);
    tick();
    chk_update("t5_upd3", 32'h504, 1'b0, 2'b01);
    tick();
    chk("t5_idle", 40'(update_valid), 40'(0));
    chk("t5_empty", 40'(count), 40'(0));

    // Async reset with a pending update pulse and 6 live entries
    do_reset();
    for (int i = 0; i < 7; i++) begin
      do_alloc(32'h600 + 32'(4 * i), 2'b10);
    end
    do_resolve(4'd0, 1'b1);
    tick();
    chk("t6_pre_valid", 40'(update_valid), 40'(1));
    chk("t6_pre_count", 40'(count), 40'(6));
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 40'(update_valid), 40'(0));
    chk("t6_rst_count", 40'(count), 40'(0));
    chk("t6_rst_tag", 40'(alloc_tag), 40'(0));
    chk("t6_rst_upc", 40'(update_pc), 40'(0));
    #2;
    rst = 1'b0;
    tick();
    chk("t6_first_tag", 40'(alloc_tag), 40'(0));
    do_alloc(32'h700, 2'b01);
    chk("t6_count", 40'(count), 40'(1));
    do_resolve(4'd0, 1'b0);
    tick();
    chk_update("t6_upd", 32'h700, 1'b0, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
